// File: rtl/hyperbus_master.sv
// HyperBus master: sends the 48-bit command/address, waits the initial access
// latency, then moves 16-bit words over the 8-bit DDR bus using a 4x system clock.
module hyperbus_master #(
  parameter int LATENCY    = 6,
  parameter int RD_TIMEOUT = 64
) (
  input  logic        CK,
  input  logic        RESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic        req_as,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_len,
  input  logic [15:0] wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        done,
  output logic        err,
  output logic        hb_ck,
  output logic        hb_ckn,
  output logic        hb_csn,
  output logic        hb_resetn,
  output logic [7:0]  dq_out,
  output logic        dq_oe,
  input  logic [7:0]  dq_in,
  output logic        rwds_out,
  output logic        rwds_oe,
  input  logic        rwds_in
);

  typedef enum logic [2:0] {
    IDLE,
    CA,
    LAT,
    WDATA,
    RDATA,
    CSHI
  } state_t;

  localparam logic [15:0] LAT_1X  = 16'(4 * LATENCY);
  localparam logic [15:0] LAT_2X  = 16'(8 * LATENCY);
  localparam logic [15:0] TO_LAST = 16'(RD_TIMEOUT - 1);

  state_t      state;
  state_t      state_nx;
  logic [15:0] cnt;
  logic [15:0] to_cnt;
  logic        rw_q;
  logic        as_q;
  logic [31:0] addr_q;
  logic [3:0]  len_q;
  logic [3:0]  wcnt;
  logic        dbl_q;
  logic        ck_q;
  logic        rwds_prev;
  logic        lo_sel;
  logic [7:0]  hi_q;
  logic [15:0] wbuf;
  logic [15:0] rd_data_q;
  logic        rd_valid_q;
  logic        err_q;
  logic        hb_resetn_q;

  logic [47:0] ca;
  logic [47:0] ca_shift;
  logic [15:0] lat_len;
  logic        stall;
  logic        rwds_edge;
  logic        rd_last;
  logic        rd_timeout;
  logic        ck_run;

  // Linear burst; the device increments/wraps the address itself.
  assign ca         = {rw_q, as_q, 1'b1, addr_q[31:3], 13'd0, addr_q[2:0]};
  assign ca_shift   = ca << {cnt[3:1], 3'b000};
  assign lat_len    = dbl_q ? LAT_2X : LAT_1X;
  assign stall      = (state == WDATA) && (cnt == 16'd0) && !wr_valid;
  assign rwds_edge  = rwds_in ^ rwds_prev;
  assign rd_last    = (state == RDATA) && rwds_edge && lo_sel && (wcnt == len_q);
  assign rd_timeout = (state == RDATA) && !rwds_edge && (to_cnt == TO_LAST);
  // hb_ck toggles at the end of even cycles, so each edge lands mid-slot.
  assign ck_run     = (state inside {CA, LAT, WDATA, RDATA}) && !cnt[0] && !stall;

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge CK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    // NOTE: default first so no path leaves state_nx unassigned (no latch).
    state_nx = state;
    unique case (state)
      IDLE:    if (req_valid) state_nx = CA;
      CA:      if (cnt == 16'd11) state_nx = (as_q && !rw_q) ? WDATA : LAT;
      LAT:     if (cnt == lat_len - 16'd1) state_nx = rw_q ? RDATA : WDATA;
      WDATA:   if (cnt == 16'd3 && wcnt == len_q) state_nx = CSHI;
      RDATA:   if (rd_last || rd_timeout) state_nx = CSHI;
      CSHI:    if (cnt == 16'd3) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CK) begin
    if (RESET) begin
      cnt         <= '0;
      to_cnt      <= '0;
      rw_q        <= 1'b0;
      as_q        <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      wcnt        <= '0;
      dbl_q       <= 1'b0;
      ck_q        <= 1'b0;
      rwds_prev   <= 1'b0;
      lo_sel      <= 1'b0;
      hi_q        <= '0;
      wbuf        <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      err_q       <= 1'b0;
      hb_resetn_q <= 1'b0;
    end else begin
      hb_resetn_q <= 1'b1;
      rwds_prev   <= rwds_in;
      rd_valid_q  <= 1'b0;

      if (state == IDLE && req_valid) begin
        rw_q   <= req_rw;
        as_q   <= req_as;
        addr_q <= req_addr;
        len_q  <= req_len;
        wcnt   <= '0;
        lo_sel <= 1'b0;
        dbl_q  <= 1'b0;
        err_q  <= 1'b0;
      end

      if (state_nx != state)                 cnt <= '0;
      else if (stall)                        cnt <= cnt;
      else if (state == WDATA && cnt == 16'd3) cnt <= '0;
      else                                   cnt <= cnt + 16'd1;

      if (state_nx == IDLE || state_nx == CSHI) ck_q <= 1'b0;
      else if (ck_run)                          ck_q <= ~ck_q;

      // Device requests doubled latency by driving RWDS high during CA.
      if (state == CA && cnt == 16'd5) dbl_q <= rwds_in;

      if (wr_ready) wbuf <= wr_data;
      if (state == WDATA && cnt == 16'd3) wcnt <= wcnt + 4'd1;

      if (state != RDATA)  to_cnt <= '0;
      else if (rwds_edge)  to_cnt <= 16'd1;
      else                 to_cnt <= to_cnt + 16'd1;

      if (state == RDATA && rwds_edge) begin
        if (!lo_sel) begin
          hi_q   <= dq_in;
          lo_sel <= 1'b1;
        end else begin
          rd_data_q  <= {hi_q, dq_in};
          rd_valid_q <= 1'b1;
          lo_sel     <= 1'b0;
          wcnt       <= wcnt + 4'd1;
        end
      end

      if (rd_timeout) err_q <= 1'b1;
    end
  end

  always_comb begin
    req_ready = 1'b0;
    wr_ready  = 1'b0;
    hb_csn    = 1'b1;
    dq_out    = 8'h00;
    dq_oe     = 1'b0;
    rwds_out  = 1'b0;
    rwds_oe   = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    unique case (state)
      IDLE: req_ready = !RESET;
      CA: begin
        hb_csn = 1'b0;
        dq_oe  = 1'b1;
        dq_out = ca_shift[47:40];
      end
      LAT: hb_csn = 1'b0;
      WDATA: begin
        hb_csn   = 1'b0;
        dq_oe    = 1'b1;
        rwds_oe  = 1'b1;
        wr_ready = (cnt == 16'd0) && wr_valid;
        // High byte goes out straight from the handshake cycle, then from wbuf.
        unique case (cnt[1:0])
          2'd0:    dq_out = wr_data[15:8];
          2'd1:    dq_out = wbuf[15:8];
          default: dq_out = wbuf[7:0];
        endcase
      end
      RDATA: hb_csn = 1'b0;
      CSHI: begin
        done = (cnt == 16'd0);
        err  = (cnt == 16'd0) && err_q;
      end
      default: ;
    endcase
  end

  assign hb_ck     = ck_q;
  assign hb_ckn    = ~ck_q;
  assign hb_resetn = hb_resetn_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_hyperbus_master.sv
// Directed bench for hyperbus_master: CA encoding, latency, write stall,
// read capture, read timeout and mid-transfer reset.
module tb_hyperbus_master;

  logic        CK = 1'b0;
  logic        RESET = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_rw = 1'b0;
  logic        req_as = 1'b0;
  logic [31:0] req_addr = '0;
  logic [3:0]  req_len = '0;
  logic [15:0] wr_data = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        done;
  logic        err;
  logic        hb_ck;
  logic        hb_ckn;
  logic        hb_csn;
  logic        hb_resetn;
  logic [7:0]  dq_out;
  logic        dq_oe;
  logic [7:0]  dq_in = '0;
  logic        rwds_out;
  logic        rwds_oe;
  logic        rwds_in = 1'b0;

  hyperbus_master #(.LATENCY(6), .RD_TIMEOUT(64)) dut (
    .CK(CK), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw), .req_as(req_as),
    .req_addr(req_addr), .req_len(req_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
    .hb_ck(hb_ck), .hb_ckn(hb_ckn), .hb_csn(hb_csn), .hb_resetn(hb_resetn),
    .dq_out(dq_out), .dq_oe(dq_oe), .dq_in(dq_in),
    .rwds_out(rwds_out), .rwds_oe(rwds_oe), .rwds_in(rwds_in)
  );

  always #5 CK = ~CK;

  int checks = 0;
  int errors = 0;

  // Bus monitor: samples on the falling edge, logs bytes on every hb_ck edge.
  int          cyc = 0;
  logic [7:0]  bq[$];
  int          bcyc[$];
  logic [1:0]  bside[$];
  logic [15:0] rdq[$];
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          both_cnt = 0;
  int          done_cyc = 0;
  int          edge_cyc = 0;
  int          viol_cnt = 0;
  logic        ck_prev = 1'b0;
  logic        rwds_prev_m = 1'b0;

  always @(negedge CK) begin
    cyc++;
    if (dq_oe === 1'b1 && hb_ck !== ck_prev) begin
      bq.push_back(dq_out);
      bcyc.push_back(cyc);
      bside.push_back({rwds_oe, rwds_out});
    end
    ck_prev = hb_ck;
    if (rwds_in !== rwds_prev_m) edge_cyc = cyc;
    rwds_prev_m = rwds_in;
    if (rd_valid === 1'b1) rdq.push_back(rd_data);
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (err === 1'b1) err_cnt++;
    if (done === 1'b1 && err === 1'b1) both_cnt++;
    if ((hb_csn === 1'b1 && hb_ck !== 1'b0) || hb_ckn !== ~hb_ck) viol_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CK);
      #1;
    end
  endtask

  task automatic clear_logs();
    bq.delete();
    bcyc.delete();
    bside.delete();
    rdq.delete();
    done_cnt = 0;
    err_cnt  = 0;
    both_cnt = 0;
  endtask

  function automatic logic [47:0] ca_bytes();
    if (bq.size() < 6) return 'x;
    return {bq[0], bq[1], bq[2], bq[3], bq[4], bq[5]};
  endfunction

  function automatic logic [15:0] byte_pair(input int i);
    if (bq.size() < i + 2) return 'x;
    return {bq[i], bq[i+1]};
  endfunction

  function automatic int byte_gap(input int i);
    if (bcyc.size() < i + 1) return -1;
    return bcyc[i] - bcyc[i-1];
  endfunction

  task automatic start_req(input logic rw, input logic as, input logic [31:0] addr,
                           input logic [3:0] len);
    bit seen;
    seen = 0;
    @(posedge CK);
    #1;
    req_valid = 1'b1;
    req_rw    = rw;
    req_as    = as;
    req_addr  = addr;
    req_len   = len;
    for (int i = 0; i < 20; i++) begin
      @(negedge CK);
      if (req_ready === 1'b1) begin
        seen = 1;
        break;
      end
    end
    chk("req_accept", seen, 1);
    @(posedge CK);
    #1;
    req_valid = 1'b0;
  endtask

  // Returns on the falling edge of the first cycle with hb_csn low.
  task automatic wait_csn_low();
    bit seen;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CK);
      if (hb_csn === 1'b0) begin
        seen = 1;
        break;
      end
    end
    chk("csn_low", seen, 1);
  endtask

  task automatic wait_wr_ready(input string tag);
    bit seen;
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CK);
      if (wr_ready === 1'b1) begin
        seen = 1;
        break;
      end
    end
    chk({tag, "_wr_ready"}, seen, 1);
    @(posedge CK);
    #1;
    wr_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    bit seen;
    int n;
    seen = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge CK);
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
    end
    chk({tag, "_done_seen"}, seen, 1);
    if (seen) begin
      n = 0;
      while (hb_csn === 1'b1 && req_ready === 1'b0 && n < 10) begin
        n++;
        @(negedge CK);
      end
      chk({tag, "_cshi_len"}, n, 4);
    end
  endtask

  initial begin
    bit stall_ok;

    // Reset values
    tick(3);
    @(negedge CK);
    chk("rst_hb", {hb_csn, hb_ck, hb_ckn, hb_resetn}, 4'b1010);
    chk("rst_oe", {dq_oe, rwds_oe, dq_out, rwds_out}, 11'd0);
    chk("rst_hs", {req_ready, wr_ready, rd_valid, done, err}, 5'd0);
    chk("rst_rd_data", rd_data, 16'h0000);
    @(posedge CK);
    #1;
    RESET = 1'b0;
    tick(2);
    @(negedge CK);
    chk("post_rst_ready", {req_ready, hb_resetn, hb_csn}, 3'b111);

    // Memory write, single word, normal latency
    clear_logs();
    rwds_in  = 1'b0;
    wr_data  = 16'hA55A;
    wr_valid = 1'b1;
    start_req(1'b0, 1'b0, 32'h0000_0010, 4'd0);
    wait_wr_ready("wr1");
    wait_done("wr1", 100);
    chk("wr1_ca", ca_bytes(), 48'h20_00_00_02_00_00);
    chk("wr1_nbytes", bq.size(), 8);
    chk("wr1_data", byte_pair(6), 16'hA55A);
    chk("wr1_latency_gap", byte_gap(6), 26);
    chk("wr1_rwds_drive", (bside.size() >= 8) ? {bside[6], bside[7]} : 4'bxxxx, 4'b1010);
    chk("wr1_done_err", {done_cnt, err_cnt}, {32'd1, 32'd0});

    // Memory read, 4 words, doubled latency
    clear_logs();
    rwds_in = 1'b1;
    start_req(1'b1, 1'b0, 32'h0000_0123, 4'd3);
    wait_csn_low();
    chk("rd_holdoff", req_ready, 1'b0);
    tick(42);
    // Edge inside the doubled latency window must be ignored.
    rwds_in = 1'b0;
    dq_in   = 8'hEE;
    tick(22);
    begin
      logic [7:0] rbytes [8];
      rbytes = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h0F, 8'h0F, 8'hC3, 8'h3C};
      for (int i = 0; i < 8; i++) begin
        dq_in   = rbytes[i];
        rwds_in = ~rwds_in;
        if (i < 7) tick(2);
      end
    end
    wait_done("rd1", 100);
    chk("rd1_ca", ca_bytes(), 48'hA0_00_00_24_00_03);
    chk("rd1_nbytes_driven", bq.size(), 6);
    chk("rd1_nwords", rdq.size(), 4);
    chk("rd1_words", (rdq.size() == 4) ? {rdq[0], rdq[1], rdq[2], rdq[3]} : 64'hx,
        64'h1234_ABCD_0F0F_C33C);
    chk("rd1_done_err", {done_cnt, err_cnt}, {32'd1, 32'd0});

    // Register write: no latency phase
    clear_logs();
    rwds_in  = 1'b0;
    wr_data  = 16'h8F1F;
    wr_valid = 1'b1;
    start_req(1'b0, 1'b1, 32'h0000_0005, 4'd0);
    wait_wr_ready("rw");
    wait_done("rw", 50);
    chk("rw_ca", ca_bytes(), 48'h60_00_00_00_00_05);
    chk("rw_data", byte_pair(6), 16'h8F1F);
    chk("rw_no_latency_gap", byte_gap(6), 2);

    // Write burst of 2 with wr_valid withheld before word 2
    clear_logs();
    wr_data  = 16'h1122;
    wr_valid = 1'b1;
    start_req(1'b0, 1'b0, 32'h0000_0040, 4'd1);
    wait_wr_ready("wst1");
    tick(4);
    stall_ok = 1;
    for (int i = 0; i < 9; i++) begin
      @(negedge CK);
      if (hb_ck !== 1'b0 || hb_csn !== 1'b0 || wr_ready !== 1'b0) stall_ok = 0;
    end
    chk("wst_stall_frozen", stall_ok, 1);
    @(posedge CK);
    #1;
    wr_data  = 16'h3344;
    wr_valid = 1'b1;
    wait_wr_ready("wst2");
    wait_done("wst", 50);
    chk("wst_ca", ca_bytes(), 48'h20_00_00_08_00_00);
    chk("wst_nbytes", bq.size(), 10);
    chk("wst_words", {byte_pair(6), byte_pair(8)}, 32'h1122_3344);
    chk("wst_word_gap", byte_gap(7), 2);
    chk("wst_stall_gap", byte_gap(8), 12);

    // Read timeout: one word delivered, then RWDS stays static
    clear_logs();
    start_req(1'b1, 1'b0, 32'h0000_0008, 4'd1);
    wait_csn_low();
    tick(40);
    dq_in   = 8'h5A;
    rwds_in = 1'b1;
    tick(2);
    dq_in   = 8'hA5;
    rwds_in = 1'b0;
    wait_done("to", 200);
    chk("to_word", (rdq.size() == 1) ? rdq[0] : 16'hxxxx, 16'h5AA5);
    chk("to_done_err", {done_cnt, err_cnt, both_cnt}, {32'd1, 32'd1, 32'd1});
    chk("to_delay", done_cyc - edge_cyc, 64);

    // Reset in the middle of a read
    clear_logs();
    start_req(1'b1, 1'b0, 32'h0000_0000, 4'd1);
    wait_csn_low();
    tick(40);
    dq_in   = 8'h77;
    rwds_in = 1'b1;
    tick(4);
    RESET = 1'b1;
    tick(1);
    RESET   = 1'b0;
    rwds_in = 1'b0;
    @(negedge CK);
    chk("mrst_bus", {hb_csn, hb_ck, dq_oe, rwds_oe}, 4'b1000);
    chk("mrst_ctl", {hb_resetn, req_ready, rd_data}, {1'b0, 1'b1, 16'h0000});
    tick(80);
    chk("mrst_silent", {done_cnt, err_cnt, 32'(rdq.size())}, 96'd0);

    // Normal transfer after the abandoned one
    clear_logs();
    wr_data  = 16'h0F0F;
    wr_valid = 1'b1;
    start_req(1'b0, 1'b0, 32'h0000_0010, 4'd0);
    wait_wr_ready("post");
    wait_done("post", 100);
    chk("post_ca", ca_bytes(), 48'h20_00_00_02_00_00);
    chk("post_data", byte_pair(6), 16'h0F0F);
    chk("post_done_err", {done_cnt, err_cnt}, {32'd1, 32'd0});

    chk("ck_idle_low_and_ckn", viol_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
